manchester_rx_ctrl: RTL and testbench

Receive-side sequencer for the Manchester decoder.
- Trains on the preamble and measures the bit period T in clk cycles.
- Programs the delay block's REF with the 3/4-bit sampling delay and issues its start strobe at each accepted mid-bit edge.
- Uses the returned delayPulse to close the boundary-edge guard window, then assembles decoded bits into bytes.

---
 rtl/manchester_pkg.sv | 39 +++
 rtl/manchester_rx_ctrl_line_sync_edge.sv | 31 +++
 rtl/manchester_rx_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_manchester_rx_ctrl.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_pkg.sv
// Shared types and helpers for the Manchester receive sequencer.
// Holds default sizing, FSM encodings and the timing arithmetic.
package manchester_pkg;

    localparam int REF_W_DEF           = 4;
    localparam int CNT_W_DEF           = 6;
    localparam int TRAIN_INTERVALS_DEF = 4;
    localparam int MIN_BIT_DEF         = 8;
    localparam int MAX_BIT_DEF         = 20;

    typedef enum logic [1:0] {
        IDLE,
        TRAIN,
        RUN
    } state_t;

    typedef enum logic {
        OPEN,
        GUARD
    } window_t;

    // Cycles allowed between accepted edges before the frame ends
    function automatic int unsigned timeout_of(
        input int unsigned t
    );
        return t + (t >> 1);
    endfunction

    // Three-quarter-bit delay, clamped to what the REF bus can carry
    function automatic int unsigned ref_of(
        input int unsigned t,
        input int unsigned ref_max
    );
        int unsigned r;
        r = (3 * t) >> 2;
        return (r > ref_max) ? ref_max : r;
    endfunction

endpackage

// File: rtl/manchester_rx_ctrl_line_sync_edge.sv
// Line input conditioning for the Manchester receiver.
// Two-flop synchroniser followed by a one-flop edge detector.
module line_sync_edge (
    input  logic clk,
    input  logic globalReset,
    input  logic lineIn,
    output logic lineSync,
    output logic lineEdge
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Resynchronise the line and keep one extra stage for edge detect
    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= lineIn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign lineSync = sync2;
    assign lineEdge = sync2 ^ sync3;

endmodule

// File: rtl/manchester_rx_ctrl.sv
// Receive sequencer: preamble training, mid-bit sampling control
// through the external delay block, and byte assembly.
module manchester_rx_ctrl
    import manchester_pkg::*;
#(
    parameter int REF_W           = REF_W_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int TRAIN_INTERVALS = TRAIN_INTERVALS_DEF,
    parameter int MIN_BIT         = MIN_BIT_DEF,
    parameter int MAX_BIT         = MAX_BIT_DEF
) (
    input  logic             clk,
    input  logic             globalReset,
    input  logic             enable,
    input  logic             lineIn,
    input  logic             delayPulse,
    output logic [REF_W-1:0] REF,
    output logic             delayStart,
    output logic [7:0]       dataOut,
    output logic             dataValid,
    output logic             locked,
    output logic             syncErr,
    output logic [CNT_W-1:0] bitPeriod
);

    localparam int TI_LOG = $clog2(TRAIN_INTERVALS);
    localparam int TC_W   = (TI_LOG > 0) ? TI_LOG : 1;
    localparam int ACC_W  = CNT_W + TI_LOG;
    localparam int unsigned REF_MAX = (1 << REF_W) - 1;

    logic line_sync;
    logic line_edge;

    state_t            state_q,      state_d;
    window_t           window_q,     window_d;
    logic [CNT_W-1:0]  int_cnt_q,    int_cnt_d;
    logic [ACC_W-1:0]  acc_q,        acc_d;
    logic [TC_W-1:0]   train_cnt_q,  train_cnt_d;
    logic [2:0]        bit_cnt_q,    bit_cnt_d;
    logic [7:0]        shreg_q,      shreg_d;
    logic [CNT_W-1:0]  bit_period_q, bit_period_d;
    logic [REF_W-1:0]  ref_q,        ref_d;
    logic [7:0]        data_q,       data_d;
    logic              data_valid_q, data_valid_d;
    logic              sync_err_q,   sync_err_d;

    logic              delay_start;
    logic              accept;
    logic [CNT_W-1:0]  interval;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  t_new;

    line_sync_edge u_line (
        .clk         (clk),
        .globalReset (globalReset),
        .lineIn      (lineIn),
        .lineSync    (line_sync),
        .lineEdge    (line_edge)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            state_q      <= IDLE;
            window_q     <= OPEN;
            int_cnt_q    <= '0;
            acc_q        <= '0;
            train_cnt_q  <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            bit_period_q <= '0;
            ref_q        <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            window_q     <= window_d;
            int_cnt_q    <= int_cnt_d;
            acc_q        <= acc_d;
            train_cnt_q  <= train_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            bit_period_q <= bit_period_d;
            ref_q        <= ref_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // Training, edge acceptance, byte assembly and timeouts
    always_comb begin
        state_d      = state_q;
        window_d     = window_q;
        int_cnt_d    = int_cnt_q;
        acc_d        = acc_q;
        train_cnt_d  = train_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        bit_period_d = bit_period_q;
        ref_d        = ref_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        delay_start  = 1'b0;
        accept       = 1'b0;
        interval     = int_cnt_q + CNT_W'(1);
        acc_sum      = acc_q + ACC_W'(interval);
        t_new        = CNT_W'(acc_sum >> TI_LOG);

        if (!enable) begin
            state_d     = IDLE;
            window_d    = OPEN;
            int_cnt_d   = '0;
            acc_d       = '0;
            train_cnt_d = '0;
            bit_cnt_d   = '0;
            shreg_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    window_d    = OPEN;
                    int_cnt_d   = '0;
                    acc_d       = '0;
                    train_cnt_d = '0;
                    bit_cnt_d   = '0;
                    shreg_d     = '0;
                    if (line_edge) state_d = TRAIN;
                end
                TRAIN: begin
                    if (line_edge) begin
                        int_cnt_d = '0;
                        if (interval < CNT_W'(MIN_BIT) ||
                            interval > CNT_W'(MAX_BIT)) begin
                            sync_err_d = 1'b1;
                            state_d    = IDLE;
                        end else if (train_cnt_q ==
                                     TC_W'(TRAIN_INTERVALS - 1)) begin
                            bit_period_d = t_new;
                            ref_d = REF_W'(ref_of(32'(t_new), REF_MAX));
                            window_d  = OPEN;
                            bit_cnt_d = '0;
                            state_d   = RUN;
                        end else begin
                            acc_d       = acc_sum;
                            train_cnt_d = train_cnt_q + TC_W'(1);
                        end
                    end else if (interval > CNT_W'(MAX_BIT)) begin
                        state_d = IDLE;
                    end else begin
                        int_cnt_d = interval;
                    end
                end
                RUN: begin
                    accept = line_edge &&
                             (window_q == OPEN || delayPulse);
                    if (window_q == GUARD && delayPulse) window_d = OPEN;
                    if (accept) begin
                        delay_start = 1'b1;
                        window_d    = GUARD;
                        int_cnt_d   = '0;
                        shreg_d     = {line_sync, shreg_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            data_d       = shreg_d;
                            data_valid_d = 1'b1;
                            bit_cnt_d    = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (32'(int_cnt_q) >=
                                 timeout_of(32'(bit_period_q))) begin
                        sync_err_d = (bit_cnt_q != 3'd0);
                        state_d    = IDLE;
                        bit_cnt_d  = '0;
                        shreg_d    = '0;
                    end else begin
                        int_cnt_d = int_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign REF        = ref_q;
    assign delayStart = delay_start;
    assign dataOut    = data_q;
    assign dataValid  = data_valid_q;
    assign locked     = (state_q == RUN);
    assign syncErr    = sync_err_q;
    assign bitPeriod  = bit_period_q;

endmodule

// File: tb/tb_manchester_rx_ctrl.sv
// Bench for manchester_rx_ctrl: Manchester line generator, delay
// block model and a frame-level reference for expected results.
module tb_manchester_rx_ctrl;

    localparam int REF_W = 4;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             globalReset;
    logic             enable;
    logic             lineIn;
    logic             delayPulse;
    logic [REF_W-1:0] REF;
    logic             delayStart;
    logic [7:0]       dataOut;
    logic             dataValid;
    logic             locked;
    logic             syncErr;
    logic [CNT_W-1:0] bitPeriod;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_dv = 0;
    int n_se = 0;
    int n_ds = 0;
    int se_cyc = 0;
    int both_err = 0;
    int tog_cyc = 0;
    int dly_cnt = 0;
    bit dly_mute = 1'b0;
    bit inj_pulse = 1'b0;
    int exp_bp = 0;
    int exp_last = 0;
    int iv[4];
    logic [7:0] dv_q[$];

    always #5 clk = ~clk;

    manchester_rx_ctrl dut (
        .clk         (clk),
        .globalReset (globalReset),
        .enable      (enable),
        .lineIn      (lineIn),
        .delayPulse  (delayPulse),
        .REF         (REF),
        .delayStart  (delayStart),
        .dataOut     (dataOut),
        .dataValid   (dataValid),
        .locked      (locked),
        .syncErr     (syncErr),
        .bitPeriod   (bitPeriod)
    );

    // External delay block: pulse REF cycles after each start strobe
    initial begin : delay_block
        delayPulse = 1'b0;
        forever begin
            @(negedge clk);
            delayPulse = 1'b0;
            if (dly_cnt > 0) begin
                dly_cnt--;
                if (dly_cnt == 0 && !dly_mute) delayPulse = 1'b1;
            end
            if (inj_pulse) begin
                delayPulse = 1'b1;
                inj_pulse  = 1'b0;
            end
            #1;
            if (delayStart === 1'b1) dly_cnt = int'(REF);
        end
    end

    // Event monitor: counts strobes once per cycle
    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (dataValid === 1'b1) begin
                n_dv++;
                dv_q.push_back(dataOut);
            end
            if (syncErr === 1'b1) begin
                n_se++;
                se_cyc = cyc;
            end
            if (delayStart === 1'b1) n_ds++;
            if (dataValid === 1'b1 && syncErr === 1'b1) both_err++;
        end
    end

    function automatic int exp_ref(input int t);
        int r;
        r = (3 * t) / 4;
        return (r > 15) ? 15 : r;
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle();
        lineIn  = ~lineIn;
        tog_cyc = cyc;
    endtask

    task automatic clear_counts();
        n_dv = 0;
        n_se = 0;
        n_ds = 0;
        dv_q.delete();
    endtask

    // Quiet line at a chosen level, then enable
    task automatic prep(input bit level);
        enable = 1'b0;
        lineIn = level;
        hold(5);
        enable = 1'b1;
        hold(2);
    endtask

    // Preamble of iv[] intervals ending at the level ~first
    task automatic run_lock(input bit first);
        prep(first);
        toggle();
        for (int i = 0; i < 4; i++) begin
            hold(iv[i]);
            toggle();
        end
    endtask

    task automatic set_iv(input int t);
        for (int i = 0; i < 4; i++) iv[i] = t;
    endtask

    // Manchester bits, LSB first, mid-bit level = bit value
    task automatic send_bits(input logic [7:0] b, input int nb,
                             input int t);
        for (int i = 0; i < nb; i++) begin
            hold(t / 2);
            if (lineIn == b[i]) toggle();
            hold(t - t / 2);
            toggle();
        end
    endtask

    task automatic test_reset();
        globalReset = 1'b0;
        enable      = 1'b0;
        lineIn      = 1'b0;
        hold(3);
        n_cmp++;
        if (REF !== 4'd0) begin
            n_err++;
            $display("FAIL rst_ref: got %0d want 0", REF);
        end
        n_cmp++;
        if (bitPeriod !== 6'd0) begin
            n_err++;
            $display("FAIL rst_bp: got %0d want 0", bitPeriod);
        end
        n_cmp++;
        if ({dataOut, dataValid, locked, syncErr, delayStart}
            !== 12'h000) begin
            n_err++;
            $display("FAIL rst_out: got %h %b%b%b%b want 00 0000",
                     dataOut, dataValid, locked, syncErr, delayStart);
        end
        globalReset = 1'b1;
        hold(3);
    endtask

    task automatic test_lock_byte();
        clear_counts();
        set_iv(16);
        run_lock(1'b1);
        send_bits(8'hA5, 8, 16);
        hold(5);
        exp_bp = 16;
        exp_last = 8'hA5;
        n_cmp++;
        if (bitPeriod !== 6'd16) begin
            n_err++;
            $display("FAIL a5_bp: got %0d want 16", bitPeriod);
        end
        n_cmp++;
        if (REF !== 4'd12) begin
            n_err++;
            $display("FAIL a5_ref: got %0d want 12", REF);
        end
        n_cmp++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL a5_locked: got %b want 1", locked);
        end
        n_cmp++;
        if (n_ds != 8) begin
            n_err++;
            $display("FAIL a5_starts: got %0d want 8", n_ds);
        end
        n_cmp++;
        if (n_dv != 1 || dv_q[0] !== 8'hA5) begin
            n_err++;
            $display("FAIL a5_byte: got %0d strobes first %h want 1 a5",
                     n_dv, (n_dv > 0) ? dv_q[0] : 8'h00);
        end
        hold(40);
        n_cmp++;
        if (locked !== 1'b0 || n_se != 0) begin
            n_err++;
            $display("FAIL a5_end: got locked %b errs %0d want 0 0",
                     locked, n_se);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] b;
        b = 8'($urandom);
        clear_counts();
        set_iv(20);
        run_lock(b[0]);
        send_bits(b, 8, 20);
        hold(5);
        exp_bp = 20;
        exp_last = int'(b);
        n_cmp++;
        if (bitPeriod !== 6'd20 || REF !== 4'd15) begin
            n_err++;
            $display("FAIL clamp: got bp %0d ref %0d want 20 15",
                     bitPeriod, REF);
        end
        n_cmp++;
        if (n_dv != 1 || dv_q[0] !== b) begin
            n_err++;
            $display("FAIL clamp_byte: got %0d strobes want 1 of %h",
                     n_dv, b);
        end
        hold(45);
    endtask

    task automatic test_train_err();
        clear_counts();
        prep(1'b0);
        toggle();
        hold(6);
        toggle();
        hold(30);
        n_cmp++;
        if (n_se != 1 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL train_err: got errs %0d locked %b want 1 0",
                     n_se, locked);
        end
        n_cmp++;
        if (bitPeriod !== CNT_W'(exp_bp)) begin
            n_err++;
            $display("FAIL train_err_bp: got %0d want %0d",
                     bitPeriod, exp_bp);
        end
    endtask

    task automatic test_partial_timeout();
        logic [7:0] b;
        int d;
        b = 8'($urandom);
        clear_counts();
        set_iv(16);
        run_lock(b[0]);
        send_bits(b, 3, 16);
        hold(40);
        d = se_cyc - tog_cyc;
        n_cmp++;
        if (n_se != 1 || n_dv != 0) begin
            n_err++;
            $display("FAIL partial: got errs %0d bytes %0d want 1 0",
                     n_se, n_dv);
        end
        n_cmp++;
        if (d < 27 || d > 31) begin
            n_err++;
            $display("FAIL partial_time: got %0d cycles want 27..31", d);
        end
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL partial_locked: got %b want 0", locked);
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] b;
        b = 8'($urandom);
        clear_counts();
        set_iv(16);
        run_lock(b[0]);
        dly_mute = 1'b1;
        send_bits(b, 1, 16);
        hold(8);
        if (lineIn == b[1]) toggle();
        hold(8);
        toggle();
        @(negedge clk);
        #2;
        inj_pulse = 1'b1;
        @(negedge clk);
        #3;
        n_cmp++;
        if (delayStart !== 1'b1) begin
            n_err++;
            $display("FAIL same_cycle: got start %b want 1", delayStart);
        end
        send_bits(b >> 2, 1, 16);
        hold(40);
        dly_mute = 1'b0;
        n_cmp++;
        if (n_ds != 2 || n_se != 1 || n_dv != 0) begin
            n_err++;
            $display("FAIL guard: got starts %0d errs %0d bytes %0d %s",
                     n_ds, n_se, n_dv, "want 2 1 0");
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'($urandom);
        clear_counts();
        set_iv(16);
        run_lock(b[0]);
        send_bits(b, 4, 16);
        hold(3);
        globalReset = 1'b0;
        #1;
        n_cmp++;
        if (locked !== 1'b0 || REF !== 4'd0 || bitPeriod !== 6'd0 ||
            dataOut !== 8'd0) begin
            n_err++;
            $display("FAIL rst_mid: got %b %0d %0d %h want 0 0 0 00",
                     locked, REF, bitPeriod, dataOut);
        end
        exp_bp = 0;
        exp_last = 0;
        hold(3);
        globalReset = 1'b1;
        hold(40);
        n_cmp++;
        if (n_dv != 0 || n_se != 0) begin
            n_err++;
            $display("FAIL rst_mid_strobes: got %0d %0d want 0 0",
                     n_dv, n_se);
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0] b;
        b = 8'($urandom);
        clear_counts();
        set_iv(16);
        run_lock(b[0]);
        exp_bp = 16;
        send_bits(b, 5, 16);
        hold(3);
        enable = 1'b0;
        hold(2);
        n_cmp++;
        if (locked !== 1'b0 || REF !== 4'd12 || bitPeriod !== 6'd16) begin
            n_err++;
            $display("FAIL en_drop: got %b %0d %0d want 0 12 16",
                     locked, REF, bitPeriod);
        end
        hold(40);
        n_cmp++;
        if (n_dv != 0 || n_se != 0 || dataOut !== 8'(exp_last)) begin
            n_err++;
            $display("FAIL en_drop_out: got %0d %0d %h want 0 0 %h",
                     n_dv, n_se, dataOut, 8'(exp_last));
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            int tn;
            int lo;
            int hi;
            int sum;
            int nb;
            logic [7:0] bytes[3];
            tn = $urandom_range(20, 8);
            lo = (tn > 8) ? tn - 1 : 8;
            hi = (tn < 20) ? tn + 1 : 20;
            sum = 0;
            for (int i = 0; i < 4; i++) begin
                iv[i] = $urandom_range(hi, lo);
                sum += iv[i];
            end
            nb = $urandom_range(3, 1);
            for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom);
            exp_bp = sum / 4;
            clear_counts();
            run_lock(bytes[0][0]);
            for (int i = 0; i < nb; i++) send_bits(bytes[i], 8, tn);
            hold(5);
            n_cmp++;
            if (bitPeriod !== CNT_W'(exp_bp) ||
                REF !== REF_W'(exp_ref(exp_bp)) || locked !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_lock: got %0d %0d %b want %0d %0d 1",
                         bitPeriod, REF, locked, exp_bp, exp_ref(exp_bp));
            end
            n_cmp++;
            if (n_dv != nb) begin
                n_err++;
                $display("FAIL b2b_count: got %0d want %0d", n_dv, nb);
            end
            for (int i = 0; i < nb && i < n_dv; i++) begin
                n_cmp++;
                if (dv_q[i] !== bytes[i]) begin
                    n_err++;
                    $display("FAIL b2b_byte%0d: got %h want %h",
                             i, dv_q[i], bytes[i]);
                end
            end
            exp_last = int'(bytes[nb - 1]);
            hold(45);
            n_cmp++;
            if (n_se != 0 || locked !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_end: got errs %0d locked %b want 0 0",
                         n_se, locked);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_byte();
        test_clamp();
        test_train_err();
        test_partial_timeout();
        test_same_cycle();
        test_reset_mid();
        test_enable_drop();
        test_back_to_back();
        n_cmp++;
        if (both_err != 0) begin
            n_err++;
            $display("FAIL dv_and_err: got %0d overlaps want 0", both_err);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
